local_mem_resp: RTL

LOCAL_MEM_RESP -- requirements
Module: local_mem_resp

---
 rtl/afu_pkg.sv | 15 +
 rtl/local_mem_resp_if.sv | 42 ++++
 rtl/local_mem_resp_line_ram.sv | 39 +++
 rtl/local_mem_resp.sv | 119 +++++++++++
 4 files changed

// File: rtl/afu_pkg.sv
// Shared types for the local memory responder.
//   line_t  : one 512-bit memory line
//   addr_t  : 32-bit cache-line address as seen on the request bus
//   state_e : responder FSM state, also exported on the debug port
package afu_pkg;
  typedef logic [511:0] line_t;
  typedef logic [31:0]  addr_t;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    READ_WAIT = 2'd2,
    WRITE_ACK = 2'd3
  } state_e;
endpackage

// File: rtl/local_mem_resp_if.sv
// Request/response bus between a requester (master) and the local memory
// responder (slave).
//   read_request_valid / write_request_valid : one-cycle request pulses
//   address / data_d                         : request line address, write data
//   buffer_addr_valid                        : responder out of INIT
//   data_valid / data_q                      : read response pulse and data
//   write_done                               : write commit pulse
//   req_dropped                              : sticky "a request was ignored"
//   dbg_state                                : responder FSM state
//
// Handshake: requests are single-cycle pulses, never held. A pulse is taken
// only if the responder is in IDLE during that cycle; a pulse in any other
// cycle is discarded and latches req_dropped. buffer_addr_valid only says the
// responder has left INIT; it is not a per-cycle ready. A requester issues
// one request, waits for its write_done or data_valid pulse, and may issue the
// next request in the following cycle.
interface local_mem_resp_if;
  import afu_pkg::*;

  logic   read_request_valid;
  logic   write_request_valid;
  addr_t  address;
  line_t  data_d;
  logic   buffer_addr_valid;
  logic   data_valid;
  logic   write_done;
  line_t  data_q;
  logic   req_dropped;
  state_e dbg_state;

  modport master (
    output read_request_valid, write_request_valid, address, data_d,
    input  buffer_addr_valid, data_valid, write_done, data_q, req_dropped,
           dbg_state
  );

  modport slave (
    input  read_request_valid, write_request_valid, address, data_d,
    output buffer_addr_valid, data_valid, write_done, data_q, req_dropped,
           dbg_state
  );
endinterface

// File: rtl/local_mem_resp_line_ram.sv
// line_ram: single-port synchronous RAM, DEPTH x 512 bits, one-cycle read.
//   clk, rst : clock; rst clears only the read-data register
//   i_we     : write i_wdata to line i_addr at the clock edge
//   i_re     : load line i_addr into o_rdata at the clock edge
//   i_addr   : line index
//   i_wdata  : write data
//   o_rdata  : read data; holds its value until the next read
module line_ram
  import afu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  line_t         i_wdata,
  output line_t         o_rdata
);

  line_t r_mem [DEPTH];
  line_t r_rdata;

  // Array kept free of reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Output register only moves on a read, so it doubles as the held read
  // data of the responder.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/local_mem_resp.sv
// local_mem_resp: single-outstanding-request memory responder.
// After reset it zero-fills its RAM one line per cycle (INIT), then serves
// one read or write at a time. Reads answer READ_LATENCY cycles after accept,
// writes answer the cycle after accept. Requests arriving while busy, or a
// read coinciding with a write, are dropped and latch req_dropped.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : local_mem_resp_if slave modport (requests in, responses out)
module local_mem_resp
  import afu_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  local_mem_resp_if.slave bus
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_e        r_state;
  logic [AW-1:0] r_init_cnt;
  logic [3:0]    r_lat_cnt;
  logic          r_data_valid;
  logic          r_write_done;
  logic          r_req_dropped;

  logic          w_idle;
  logic          w_acc_wr;
  logic          w_acc_rd;
  logic          w_drop;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_addr;
  line_t         w_ram_wdata;
  line_t         w_ram_rdata;
  logic          w_unused_addr;

  // Upper address bits are ignored: addresses wrap onto DEPTH lines.
  assign w_unused_addr = ^bus.address[31:AW];

  assign w_idle   = (r_state == IDLE);
  assign w_acc_wr = w_idle & bus.write_request_valid;
  // A write wins over a simultaneous read.
  assign w_acc_rd = w_idle & bus.read_request_valid & ~bus.write_request_valid;
  assign w_drop   = (w_idle & bus.read_request_valid & bus.write_request_valid) |
                    (~w_idle & (bus.read_request_valid | bus.write_request_valid));

  assign w_ram_addr  = (r_state == INIT) ? r_init_cnt : bus.address[AW-1:0];
  assign w_ram_wdata = (r_state == INIT) ? '0 : bus.data_d;
  assign w_ram_we    = ~rst & ((r_state == INIT) | w_acc_wr);
  assign w_ram_re    = ~rst & w_acc_rd;

  line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= INIT;
      r_init_cnt    <= '0;
      r_lat_cnt     <= '0;
      r_data_valid  <= 1'b0;
      r_write_done  <= 1'b0;
      r_req_dropped <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_write_done <= 1'b0;
      if (w_drop) r_req_dropped <= 1'b1;

      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == AW'(DEPTH - 1)) r_state <= IDLE;
        end
        IDLE: begin
          if (w_acc_wr) begin
            r_state      <= WRITE_ACK;
            r_write_done <= 1'b1;
          end else if (w_acc_rd) begin
            r_state      <= READ_WAIT;
            r_lat_cnt    <= LAT_M1;
            // Latency 1 responds in the cycle right after accept.
            r_data_valid <= (READ_LATENCY == 1);
          end
        end
        READ_WAIT: begin
          // r_lat_cnt == 0 is the cycle data_valid is high.
          if (r_lat_cnt == 4'd0) begin
            r_state <= IDLE;
          end else begin
            r_lat_cnt    <= r_lat_cnt - 4'd1;
            r_data_valid <= (r_lat_cnt == 4'd1);
          end
        end
        WRITE_ACK: r_state <= IDLE;
        default:   r_state <= INIT;
      endcase
    end
  end

  assign bus.buffer_addr_valid = (r_state != INIT);
  assign bus.data_valid        = r_data_valid;
  assign bus.write_done        = r_write_done;
  assign bus.data_q            = w_ram_rdata;
  assign bus.req_dropped       = r_req_dropped;
  assign bus.dbg_state         = r_state;
endmodule
